// File: rtl/find_max_writer_if.sv
// Bundle between the find-max writer, the sample source, the frame RAM
// port A and the find-max reader handshake.
interface find_max_writer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              finishb;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              readyb;

  // Writer side: consumes the sample stream and the reader's finish flag,
  // drives RAM port A and the ready flag.
  modport master (
    input  sample_valid, sample_data, finishb,
    output wea, addra, dina, readyb
  );

  // Environment side: sample source, RAM and reader.
  modport slave (
    output sample_valid, sample_data, finishb,
    input  wea, addra, dina, readyb
  );
endinterface

// File: rtl/find_max_writer.sv
// Find-max writer: captures DEPTH (optionally decimated) samples into port A
// of the shared frame RAM, raises readyb once the frame is complete and holds
// it until the reader signals completion with a rising edge on finishb.
module find_max_writer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int DEPTH    = 128,
  parameter int DECIMATE = 1
)(
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 arm,
  find_max_writer_if.master    bus,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic [7:0]           drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FILL     = 2'd1,
    S_HANDOFF  = 2'd2,
    S_WAIT_FIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        DEC_LAST  = 8'(DECIMATE - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [7:0]          dec_cnt_q, dec_cnt_d;
  logic                finishb_q;
  logic                wea_q, wea_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [DATA_W-1:0]   dina_q, dina_d;
  logic                readyb_q, readyb_d;
  logic                busy_q, busy_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic                fin_rise;

  // Saturating increment for the dropped-sample counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign fin_rise = bus.finishb & ~finishb_q;

  // Next-state and registered-output logic for the capture FSM.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    dec_cnt_d   = dec_cnt_q;
    wea_d       = 1'b0;
    addra_d     = addra_q;
    dina_d      = dina_q;
    readyb_d    = readyb_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    case (state_q)
      S_IDLE: begin
        readyb_d = 1'b0;
        if (arm) begin
          state_d   = S_FILL;
          wr_ptr_d  = '0;
          dec_cnt_d = '0;
        end
      end

      S_FILL: begin
        // Dropping arm abandons the partial frame; that cycle's sample is not written.
        if (!arm) begin
          state_d = S_IDLE;
        end else if (bus.sample_valid) begin
          if (dec_cnt_q == DEC_LAST) begin
            wea_d     = 1'b1;
            addra_d   = wr_ptr_q;
            dina_d    = bus.sample_data;
            dec_cnt_d = '0;
            wr_ptr_d  = wr_ptr_q + 1'b1;
            if (wr_ptr_q == LAST_ADDR) begin
              state_d = S_HANDOFF;
            end
          end else begin
            dec_cnt_d = dec_cnt_q + 8'd1;
          end
        end
      end

      S_HANDOFF: begin
        // One cycle gap after the last write so the final address is in RAM
        // before the reader sees readyb.
        readyb_d    = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = S_WAIT_FIN;
      end

      S_WAIT_FIN: begin
        if (bus.sample_valid) begin
          drop_cnt_d = sat_inc8(drop_cnt_q);
        end
        if (fin_rise) begin
          readyb_d = 1'b0;
          if (arm) begin
            state_d   = S_FILL;
            wr_ptr_d  = '0;
            dec_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      dec_cnt_q   <= '0;
      finishb_q   <= 1'b0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      readyb_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      dec_cnt_q   <= dec_cnt_d;
      finishb_q   <= bus.finishb;
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      readyb_q    <= readyb_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.wea    = wea_q;
  assign bus.addra  = addra_q;
  assign bus.dina   = dina_q;
  assign bus.readyb = readyb_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_find_max_writer.sv
// Directed testbench for find_max_writer: one DUT without decimation and one
// with DECIMATE=4, sharing clock and reset.
module tb_find_max_writer;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        arm4;
  logic        busy, busy4;
  logic [15:0] frame_cnt, frame_cnt4;
  logic [7:0]  drop_cnt, drop_cnt4;

  int checks = 0;
  int passes = 0;

  find_max_writer_if #(.DATA_W(8), .ADDR_W(7)) ifa ();
  find_max_writer_if #(.DATA_W(8), .ADDR_W(7)) if4 ();

  find_max_writer #(.DATA_W(8), .ADDR_W(7), .DEPTH(128), .DECIMATE(1)) dut (
    .clk_in(clk), .rst(rst), .arm(arm), .bus(ifa),
    .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  find_max_writer #(.DATA_W(8), .ADDR_W(7), .DEPTH(128), .DECIMATE(4)) dut4 (
    .clk_in(clk), .rst(rst), .arm(arm4), .bus(if4),
    .busy(busy4), .frame_cnt(frame_cnt4), .drop_cnt(drop_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (ifa.wea !== 1'b0) $display("FAIL reset_wea got=%b exp=0", ifa.wea); else passes++;
    checks++; if (ifa.addra !== 7'd0) $display("FAIL reset_addra got=%0d exp=0", ifa.addra); else passes++;
    checks++; if (ifa.dina !== 8'd0) $display("FAIL reset_dina got=%0h exp=0", ifa.dina); else passes++;
    checks++; if (ifa.readyb !== 1'b0) $display("FAIL reset_readyb got=%b exp=0", ifa.readyb); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
    checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); else passes++;
    checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); else passes++;
    checks++; if (busy4 !== 1'b0) $display("FAIL reset_busy4 got=%b exp=0", busy4); else passes++;
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else passes++;
  endtask

  task automatic test_fill();
    arm = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL fill_busy got=%b exp=1", busy); else passes++;
    checks++; if (ifa.wea !== 1'b0) $display("FAIL fill_arm_wea got=%b exp=0", ifa.wea); else passes++;
    ifa.sample_valid = 1'b1;
    ifa.sample_data  = 8'h10;
    for (int i = 0; i < 128; i++) begin
      tick();
      checks++; if (ifa.wea !== 1'b1) $display("FAIL fill_wea i=%0d got=%b exp=1", i, ifa.wea); else passes++;
      checks++; if (ifa.addra !== 7'(i)) $display("FAIL fill_addra got=%0d exp=%0d", ifa.addra, i); else passes++;
      checks++; if (ifa.dina !== 8'(16 + i)) $display("FAIL fill_dina i=%0d got=%0h exp=%0h", i, ifa.dina, 8'(16 + i)); else passes++;
      checks++; if (ifa.readyb !== 1'b0) $display("FAIL fill_readyb_early i=%0d got=%b exp=0", i, ifa.readyb); else passes++;
      ifa.sample_data = 8'(16 + i + 1);
    end
    ifa.sample_valid = 1'b0;
    tick();
    checks++; if (ifa.readyb !== 1'b1) $display("FAIL handoff_readyb got=%b exp=1", ifa.readyb); else passes++;
    checks++; if (ifa.wea !== 1'b0) $display("FAIL handoff_wea got=%b exp=0", ifa.wea); else passes++;
    checks++; if (frame_cnt !== 16'd1) $display("FAIL handoff_frame_cnt got=%0d exp=1", frame_cnt); else passes++;
  endtask

  task automatic test_drop();
    ifa.sample_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      checks++; if (ifa.wea !== 1'b0) $display("FAIL drop_wea i=%0d got=%b exp=0", i, ifa.wea); else passes++;
    end
    ifa.sample_valid = 1'b0;
    tick();
    checks++; if (drop_cnt !== 8'd255) $display("FAIL drop_sat got=%0d exp=255", drop_cnt); else passes++;
    checks++; if (ifa.readyb !== 1'b1) $display("FAIL drop_readyb_held got=%b exp=1", ifa.readyb); else passes++;
    ifa.finishb = 1'b1;
    tick();
    checks++; if (ifa.readyb !== 1'b0) $display("FAIL finish_readyb got=%b exp=0", ifa.readyb); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL finish_busy got=%b exp=1", busy); else passes++;
    ifa.finishb      = 1'b0;
    ifa.sample_valid = 1'b1;
    ifa.sample_data  = 8'hA5;
    tick();
    checks++; if (ifa.wea !== 1'b1) $display("FAIL refill_wea got=%b exp=1", ifa.wea); else passes++;
    checks++; if (ifa.addra !== 7'd0) $display("FAIL refill_addra got=%0d exp=0", ifa.addra); else passes++;
    checks++; if (ifa.dina !== 8'hA5) $display("FAIL refill_dina got=%0h exp=a5", ifa.dina); else passes++;
  endtask

  task automatic test_abort();
    for (int i = 1; i < 50; i++) begin
      ifa.sample_data = 8'(i);
      tick();
    end
    checks++; if (ifa.addra !== 7'd49) $display("FAIL abort_last_addra got=%0d exp=49", ifa.addra); else passes++;
    arm = 1'b0;
    ifa.sample_valid = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passes++;
    checks++; if (ifa.wea !== 1'b0) $display("FAIL abort_wea got=%b exp=0", ifa.wea); else passes++;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (ifa.readyb !== 1'b0) $display("FAIL abort_readyb got=%b exp=0", ifa.readyb); else passes++;
    end
    checks++; if (frame_cnt !== 16'd1) $display("FAIL abort_frame_cnt got=%0d exp=1", frame_cnt); else passes++;
    arm = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL rearm_busy got=%b exp=1", busy); else passes++;
    ifa.sample_valid = 1'b1;
    ifa.sample_data  = 8'h33;
    tick();
    checks++; if (ifa.wea !== 1'b1) $display("FAIL rearm_wea got=%b exp=1", ifa.wea); else passes++;
    checks++; if (ifa.addra !== 7'd0) $display("FAIL rearm_addra got=%0d exp=0", ifa.addra); else passes++;
    checks++; if (ifa.dina !== 8'h33) $display("FAIL rearm_dina got=%0h exp=33", ifa.dina); else passes++;
  endtask

  task automatic test_finish_held();
    ifa.finishb = 1'b1;
    for (int i = 1; i < 128; i++) begin
      ifa.sample_data = 8'(i);
      tick();
    end
    checks++; if (ifa.addra !== 7'd127) $display("FAIL held_last_addra got=%0d exp=127", ifa.addra); else passes++;
    ifa.sample_valid = 1'b0;
    tick();
    checks++; if (ifa.readyb !== 1'b1) $display("FAIL held_readyb_rise got=%b exp=1", ifa.readyb); else passes++;
    checks++; if (frame_cnt !== 16'd2) $display("FAIL held_frame_cnt got=%0d exp=2", frame_cnt); else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ifa.readyb !== 1'b1) $display("FAIL held_high_release got=%b exp=1", ifa.readyb); else passes++;
    end
    ifa.finishb = 1'b0;
    tick();
    checks++; if (ifa.readyb !== 1'b1) $display("FAIL held_fall_release got=%b exp=1", ifa.readyb); else passes++;
    ifa.finishb = 1'b1;
    tick();
    checks++; if (ifa.readyb !== 1'b0) $display("FAIL held_fresh_edge got=%b exp=0", ifa.readyb); else passes++;
    ifa.finishb = 1'b0;
    checks++; if (drop_cnt !== 8'd255) $display("FAIL held_drop_cnt got=%0d exp=255", drop_cnt); else passes++;
  endtask

  task automatic test_reset_ready();
    ifa.sample_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      ifa.sample_data = 8'(i);
      tick();
    end
    ifa.sample_valid = 1'b0;
    tick();
    checks++; if (ifa.readyb !== 1'b1) $display("FAIL rr_readyb got=%b exp=1", ifa.readyb); else passes++;
    checks++; if (frame_cnt !== 16'd3) $display("FAIL rr_frame_cnt got=%0d exp=3", frame_cnt); else passes++;
    rst = 1'b0;
    tick();
    checks++; if (ifa.readyb !== 1'b0) $display("FAIL rr_rst_readyb got=%b exp=0", ifa.readyb); else passes++;
    checks++; if (ifa.wea !== 1'b0) $display("FAIL rr_rst_wea got=%b exp=0", ifa.wea); else passes++;
    checks++; if (ifa.addra !== 7'd0) $display("FAIL rr_rst_addra got=%0d exp=0", ifa.addra); else passes++;
    checks++; if (ifa.dina !== 8'd0) $display("FAIL rr_rst_dina got=%0h exp=0", ifa.dina); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rr_rst_busy got=%b exp=0", busy); else passes++;
    checks++; if (frame_cnt !== 16'd0) $display("FAIL rr_rst_frame_cnt got=%0d exp=0", frame_cnt); else passes++;
    checks++; if (drop_cnt !== 8'd0) $display("FAIL rr_rst_drop_cnt got=%0d exp=0", drop_cnt); else passes++;
    rst = 1'b1;
    ifa.sample_valid = 1'b1;
    ifa.sample_data  = 8'h77;
    tick();
    checks++; if (ifa.wea !== 1'b0) $display("FAIL rr_idle_wea got=%b exp=0", ifa.wea); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL rr_restart_busy got=%b exp=1", busy); else passes++;
    tick();
    checks++; if (ifa.wea !== 1'b1) $display("FAIL rr_restart_wea got=%b exp=1", ifa.wea); else passes++;
    checks++; if (ifa.addra !== 7'd0) $display("FAIL rr_restart_addra got=%0d exp=0", ifa.addra); else passes++;
    checks++; if (ifa.dina !== 8'h77) $display("FAIL rr_restart_dina got=%0h exp=77", ifa.dina); else passes++;
    arm = 1'b0;
    ifa.sample_valid = 1'b0;
    tick();
  endtask

  task automatic test_decimate();
    arm4 = 1'b1;
    tick();
    if4.sample_valid = 1'b1;
    if4.sample_data  = 8'd0;
    for (int k = 0; k < 512; k++) begin
      tick();
      if ((k % 4) == 3) begin
        checks++; if (if4.wea !== 1'b1) $display("FAIL dec_wea k=%0d got=%b exp=1", k, if4.wea); else passes++;
        checks++; if (if4.addra !== 7'(k / 4)) $display("FAIL dec_addra k=%0d got=%0d exp=%0d", k, if4.addra, k / 4); else passes++;
        checks++; if (if4.dina !== 8'(k)) $display("FAIL dec_dina k=%0d got=%0d exp=%0d", k, if4.dina, 8'(k)); else passes++;
      end else begin
        checks++; if (if4.wea !== 1'b0) $display("FAIL dec_skip k=%0d got=%b exp=0", k, if4.wea); else passes++;
      end
      if4.sample_data = 8'(k + 1);
    end
    if4.sample_valid = 1'b0;
    checks++; if (if4.readyb !== 1'b0) $display("FAIL dec_readyb_early got=%b exp=0", if4.readyb); else passes++;
    tick();
    checks++; if (if4.readyb !== 1'b1) $display("FAIL dec_readyb got=%b exp=1", if4.readyb); else passes++;
    checks++; if (frame_cnt4 !== 16'd1) $display("FAIL dec_frame_cnt got=%0d exp=1", frame_cnt4); else passes++;
  endtask

  initial begin
    rst  = 1'b0;
    arm  = 1'b0;
    arm4 = 1'b0;
    ifa.sample_valid = 1'b0;
    ifa.sample_data  = 8'd0;
    ifa.finishb      = 1'b0;
    if4.sample_valid = 1'b0;
    if4.sample_data  = 8'd0;
    if4.finishb      = 1'b0;

    test_reset();
    test_fill();
    test_drop();
    test_abort();
    test_finish_held();
    test_reset_ready();
    test_decimate();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/find_max_writer.md
Name: find_max_writer

Overview:
- Upstream stage of the find-max reader: captures a frame of DEPTH samples from the sample stream and writes them into port A of the shared dual-port frame RAM.
- When the frame is complete it raises readyb. The reader starts on the rising edge of readyb.
- It holds the frame until the reader/find-max reports finishb, then re-arms for the next frame.
- It also provides decimation, frame counting and dropped-sample accounting.

Parameters:
- DATA_W, 8, sample and RAM data width
- ADDR_W, 7, RAM address width
- DEPTH, 128, samples per frame; must equal 2^ADDR_W
- DECIMATE, 1, write every DECIMATE-th valid sample (1 = no decimation); range 1..255

Ports:
- clk_in  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous active-low reset
- arm  input  1  level; high enables capture. Held high, frames are captured back to back.
- sample_valid  input  1  sample_data is valid this cycle
- sample_data  input  DATA_W  incoming sample
- finishb  input  1  from find-max; its rising edge means the frame has been consumed
- wea  output  1  RAM port-A write enable
- addra  output  ADDR_W  RAM port-A address
- dina  output  DATA_W  RAM port-A write data
- readyb  output  1  frame is in RAM and readable by port B
- busy  output  1  state is not IDLE
- frame_cnt  output  16  frames handed off, wraps at 2^16
- drop_cnt  output  8  valid samples discarded while waiting for finishb; saturates at 255

Behaviour:
- Reset (rst==0 on a clock edge):
  - state=IDLE.
  - wea=0, addra=0, dina=0, readyb=0, busy=0, frame_cnt=0, drop_cnt=0.
  - Write pointer, decimation counter and finishb edge register are cleared.
  - Reset mid-frame discards the partial frame; no readyb is issued.
- All outputs are registered.
  - Write latency: sample_valid/sample_data sampled at edge N appear as wea/addra/dina after edge N.
- finishb edge detect: fin_rise = finishb & !finishb_r.
  - finishb_r is updated every cycle.
- IDLE:
  - wea=0, readyb=0. Samples are ignored and not counted.
  - arm==1 -> FILL with wr_ptr=0 and dec_cnt=0.
- FILL:
  - On each sample_valid: if dec_cnt==DECIMATE-1, issue a write (wea=1, addra=wr_ptr, dina=sample_data), set dec_cnt=0 and wr_ptr+1. Otherwise dec_cnt+1 and no write.
  - wea is a single-cycle pulse per accepted sample; it is 0 on cycles without a write.
  - The write to address DEPTH-1 moves the state to HANDOFF. wr_ptr wraps to 0.
  - arm==0 while in FILL aborts to IDLE the next cycle. The partial frame is abandoned, no readyb, frame_cnt unchanged.
- HANDOFF (one cycle):
  - readyb is set to 1, so it rises exactly one cycle after the last wea pulse. This guarantees address DEPTH-1 is written before the reader's first read.
  - frame_cnt+1. Go to WAIT_FINISH.
- WAIT_FINISH:
  - readyb held at 1, wea=0.
  - Every sample_valid increments drop_cnt, saturating at 255. drop_cnt is cleared only by reset.
  - On fin_rise: readyb=0. Go to FILL if arm==1 (wr_ptr=0, dec_cnt=0), else IDLE.
  - Dropping arm while in WAIT_FINISH does not release readyb; the handshake must complete first.
  - A sample_valid in the same cycle as fin_rise is counted as dropped, not written.
- fin_rise in IDLE, FILL or HANDOFF is ignored.
  - A finishb already high on entry to WAIT_FINISH is not a rising edge; completion waits for a fresh rising edge.
- readyb low time between frames is at least DEPTH*DECIMATE cycles, because a full FILL precedes every rise. The reader therefore always sees a clean rising edge per frame.
- busy = (state != IDLE), registered.

Test Plan:
- Reset then arm=1, sample_valid every cycle, sample_data=addr+0x10 -> wea pulses at addra 0..127 with dina 0x10..0x8F; readyb rises 1 cycle after the addra=127 write; frame_cnt=1.
- In WAIT_FINISH, drive 300 sample_valid pulses, then pulse finishb -> drop_cnt=255 (saturated); readyb falls the cycle after finishb's rising edge; FILL restarts at addra=0.
- DECIMATE=4, continuous valid, data=cycle index -> writes only every 4th sample (data 3,7,11,...); readyb rises after 512 valid cycles.
- arm=0 after 50 writes -> return to IDLE, no readyb, frame_cnt unchanged. Re-arm -> next write at addra=0.
- finishb held high before readyb rises, then finishb falls and rises again -> only the later rising edge releases readyb.
- rst=0 for one cycle while readyb=1 -> next cycle all outputs 0, state IDLE; with arm high, capture restarts at addra=0.
